pacman_motion_ctrl: RTL
=======================

Name: pacman_motion_ctrl

Overview:
- Per-frame motion and animation sequencer for the Pac-Man sprite.
- Once per frame it picks a direction from the joystick, asks the tile-map wall lookup whether the move is legal, and updates the sprite origin and mouth toggle.
- Its outputs (pac_x, pac_y, mouth_state) drive the sprite/background pixel compositor. The wall lookup is a shared port to the tile map.

Parameters:
- SPRITE_SIZE, 8: sprite edge in pixels; also the tile edge.
- TILE_SHIFT, 3: log2 of the tile edge.
- STEP, 1: pixels moved per frame.
- X_MAX, 1912: largest legal pac_x (screen width minus SPRITE_SIZE).
- Y_MAX, 1072: largest legal pac_y.
- START_X, 8: pac_x after reset.
- START_Y, 8: pac_y after reset.
- MOUTH_PERIOD, 8: number of moved frames between mouth toggles; minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- dir_btn  in  4  {down,up,left,right}; level, synchronised upstream
- wall_req  out  1  wall lookup request
- wall_tx  out  9  tile column of the query
- wall_ty  out  9  tile row of the query
- wall_ack  in  1  lookup done; wall_hit valid in the same cycle
- wall_hit  in  1  1 = queried tile is a wall
- pac_x  out  12  sprite origin X
- pac_y  out  12  sprite origin Y
- mouth_state  out  1  1 = open mouth
- cur_dir  out  2  0 right, 1 left, 2 up, 3 down
- busy  out  1  high while not IDLE
- move_done  out  1  one-cycle pulse when a frame's sequence ends

Behaviour:
- Reset values: pac_x=START_X, pac_y=START_Y, cur_dir=0, mouth_state=1, wall_req=0, wall_tx=0, wall_ty=0, busy=0, move_done=0, frame counter=0, FSM=IDLE.
- Reset asserted mid-sequence: all of the above apply on the next clk edge; the outstanding lookup is abandoned and a late wall_ack is ignored.
- FSM states: IDLE, TRY_A, TRY_B, CUR_A, CUR_B, UPDATE, DONE.
- IDLE:
  - On frame_tick, latch req_dir from dir_btn with priority right > left > up > down.
  - No button pressed: req_dir = cur_dir.
  - frame_tick in any state other than IDLE is ignored (no queueing).
- Candidate position: pac position ±STEP along the direction; compute in 13 bits.
  - Candidate <0 or >X_MAX / >Y_MAX: blocked, no query issued.
- Leading-edge corners of the candidate box (nx,ny):
  - right: (nx+SIZE-1, ny) and (nx+SIZE-1, ny+SIZE-1)
  - left: (nx, ny) and (nx, ny+SIZE-1)
  - up: (nx, ny) and (nx+SIZE-1, ny)
  - down: (nx, ny+SIZE-1) and (nx+SIZE-1, ny+SIZE-1)
  - Tile coordinate = corner >> TILE_SHIFT, truncated to 9 bits.
- TRY_A / TRY_B: query corner A, then corner B, for req_dir.
  - req_dir == cur_dir: go straight from IDLE to CUR_A.
- CUR_A / CUR_B: same two queries for cur_dir.
- Query handshake:
  - Assert wall_req with wall_tx/ty stable; hold until a cycle where wall_ack=1.
  - Sample wall_hit in that cycle; deassert wall_req the next cycle.
  - wall_ack may arrive in the first request cycle. No timeout.
- Transitions:
  - hit in TRY_x (or out of bounds): go to CUR_A.
  - TRY_B clear: commit cur_dir=req_dir, go to UPDATE.
  - hit in CUR_x (or out of bounds): blocked, go to DONE without moving.
  - CUR_B clear: go to UPDATE.
- UPDATE:
  - Load pac_x/pac_y with the candidate for cur_dir.
  - Increment frame counter; at MOUTH_PERIOD-1, wrap to 0 and toggle mouth_state.
- DONE: pulse move_done for one cycle, return to IDLE.
- Blocked frame: position, mouth_state and counter hold.
- pac_x/pac_y change only in UPDATE, at most once per frame_tick.
- Worst-case latency: 4 lookups + 3 cycles, well within vblank.

Test Plan:
- Reset, then frame_tick with no button, lookup acks in 1 cycle with wall_hit=0 -> pac_x 8→9, pac_y=8, cur_dir=0, move_done pulses; queries are (2,1) then (2,1) (x=16,y=8 and x=16,y=15).
- From (8,8) moving right, press up; wall_hit=1 on the first TRY query -> falls back to right, pac_x=9, cur_dir stays 0, 3 lookups total.
- Both directions blocked -> pac unchanged, mouth_state unchanged, move_done still pulses.
- 16 consecutive unblocked frames -> mouth_state toggles at frames 8 and 16: 1→0→1.
- pac_x=0 with left pressed, right blocked -> no left query issued, one CUR query pair issued, position held.
- wall_ack delayed 5 cycles with a second frame_tick during the wait, then rst_n low mid-query -> wall_req held steady during the wait, second tick ignored; after reset all outputs at reset values and the late ack causes no move.

Source files
------------

// File: rtl/pacman_motion_ctrl.sv
// pacman_motion_ctrl
//   Per-frame motion and animation sequencer for the Pac-Man sprite. On each
//   frame_tick it picks a direction from the joystick and checks the two
//   leading-edge corners of the candidate sprite box against the tile map.
//   If the requested direction is blocked, it falls back to the current
//   direction. When a move is legal, it updates the sprite origin and the
//   mouth animation.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   frame_tick            one-cycle start-of-vblank pulse
//   dir_btn[3:0]          {down,up,left,right} joystick levels
//   wall_req/tx/ty        tile-map lookup request and tile coordinates
//   wall_ack/wall_hit     lookup completion and result (same cycle)
//   pac_x/pac_y           sprite origin
//   mouth_state           1 = open mouth
//   cur_dir               0 right, 1 left, 2 up, 3 down
//   busy                  high while a frame sequence is in progress
//   move_done             one-cycle pulse at the end of each frame sequence
module pacman_motion_ctrl #(
  parameter int SPRITE_SIZE  = 8,
  parameter int TILE_SHIFT   = 3,
  parameter int STEP         = 1,
  parameter int X_MAX        = 1912,
  parameter int Y_MAX        = 1072,
  parameter int START_X      = 8,
  parameter int START_Y      = 8,
  parameter int MOUTH_PERIOD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic [3:0]  dir_btn,
  output logic        wall_req,
  output logic [8:0]  wall_tx,
  output logic [8:0]  wall_ty,
  input  logic        wall_ack,
  input  logic        wall_hit,
  output logic [11:0] pac_x,
  output logic [11:0] pac_y,
  output logic        mouth_state,
  output logic [1:0]  cur_dir,
  output logic        busy,
  output logic        move_done
);

  localparam int CNT_W = (MOUTH_PERIOD > 1) ? $clog2(MOUTH_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOUTH_PERIOD - 1);
  localparam logic [12:0] STEP_W  = 13'(STEP);
  localparam logic [12:0] SIZE_M1 = 13'(SPRITE_SIZE - 1);
  localparam logic [12:0] XMAX_W  = 13'(X_MAX);
  localparam logic [12:0] YMAX_W  = 13'(Y_MAX);

  typedef enum logic [2:0] {
    ST_IDLE, ST_TRY_A, ST_TRY_B, ST_CUR_A, ST_CUR_B, ST_UPDATE, ST_DONE
  } state_e;

  typedef struct packed {
    logic        oob;
    logic [12:0] nx;
    logic [12:0] ny;
  } cand_t;

  // Joystick priority: right > left > up > down; no button keeps the current direction.
  function automatic logic [1:0] pick_dir(input logic [3:0] btn, input logic [1:0] dflt);
    logic [1:0] d;
    d = dflt;
    if (btn[0])      d = 2'd0;
    else if (btn[1]) d = 2'd1;
    else if (btn[2]) d = 2'd2;
    else if (btn[3]) d = 2'd3;
    else             d = dflt;
    return d;
  endfunction

  // Candidate origin one STEP along dir. The 13th bit absorbs underflow,
  // so a move past the left or top edge is flagged by comparison before subtracting.
  function automatic cand_t calc_cand(input logic [1:0] dir, input logic [11:0] px,
                                      input logic [11:0] py);
    cand_t c;
    c.nx  = {1'b0, px};
    c.ny  = {1'b0, py};
    c.oob = 1'b0;
    case (dir)
      2'd0: begin c.nx = {1'b0, px} + STEP_W; c.oob = (c.nx > XMAX_W); end
      2'd1: begin c.nx = {1'b0, px} - STEP_W; c.oob = ({1'b0, px} < STEP_W); end
      2'd2: begin c.ny = {1'b0, py} - STEP_W; c.oob = ({1'b0, py} < STEP_W); end
      2'd3: begin c.ny = {1'b0, py} + STEP_W; c.oob = (c.ny > YMAX_W); end
      default: c.oob = 1'b1;
    endcase
    return c;
  endfunction

  // Tile coordinates {tx,ty} of leading-edge corner A (sel_b=0) or B (sel_b=1).
  function automatic logic [17:0] corner_tiles(input logic [1:0] dir, input logic [12:0] nx,
                                               input logic [12:0] ny, input logic sel_b);
    logic [12:0] cx;
    logic [12:0] cy;
    cx = nx;
    cy = ny;
    case (dir)
      2'd0: begin cx = nx + SIZE_M1; cy = sel_b ? ny + SIZE_M1 : ny; end
      2'd1: begin cx = nx;           cy = sel_b ? ny + SIZE_M1 : ny; end
      2'd2: begin cy = ny;           cx = sel_b ? nx + SIZE_M1 : nx; end
      2'd3: begin cy = ny + SIZE_M1; cx = sel_b ? nx + SIZE_M1 : nx; end
      default: begin cx = nx; cy = ny; end
    endcase
    return {9'(cx >> TILE_SHIFT), 9'(cy >> TILE_SHIFT)};
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       req_dir_q, req_dir_d;
  logic [1:0]       cur_dir_q, cur_dir_d;
  logic [11:0]      pac_x_q, pac_x_d, pac_y_q, pac_y_d;
  logic             mouth_q, mouth_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wall_req_q, wall_req_d;
  logic [8:0]       wall_tx_q, wall_tx_d, wall_ty_q, wall_ty_d;
  logic             busy_q, busy_d;
  logic             move_done_q, move_done_d;

  logic        is_try_s;
  logic        sel_b_s;
  logic [1:0]  q_dir_s;
  cand_t       q_cand_s;
  logic [17:0] q_tiles_s;
  state_e      fail_state_s;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_dir_q   <= 2'd0;
      cur_dir_q   <= 2'd0;
      pac_x_q     <= 12'(START_X);
      pac_y_q     <= 12'(START_Y);
      mouth_q     <= 1'b1;
      cnt_q       <= '0;
      wall_req_q  <= 1'b0;
      wall_tx_q   <= 9'd0;
      wall_ty_q   <= 9'd0;
      busy_q      <= 1'b0;
      move_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_dir_q   <= req_dir_d;
      cur_dir_q   <= cur_dir_d;
      pac_x_q     <= pac_x_d;
      pac_y_q     <= pac_y_d;
      mouth_q     <= mouth_d;
      cnt_q       <= cnt_d;
      wall_req_q  <= wall_req_d;
      wall_tx_q   <= wall_tx_d;
      wall_ty_q   <= wall_ty_d;
      busy_q      <= busy_d;
      move_done_q <= move_done_d;
    end
  end

  // Next-state logic: lookup sequencing, fallback to the current direction, and position/mouth update.
  always_comb begin
    state_d    = state_q;
    req_dir_d  = req_dir_q;
    cur_dir_d  = cur_dir_q;
    pac_x_d    = pac_x_q;
    pac_y_d    = pac_y_q;
    mouth_d    = mouth_q;
    cnt_d      = cnt_q;
    wall_req_d = wall_req_q;
    wall_tx_d  = wall_tx_q;
    wall_ty_d  = wall_ty_q;

    is_try_s     = (state_q == ST_TRY_A) || (state_q == ST_TRY_B);
    sel_b_s      = (state_q == ST_TRY_B) || (state_q == ST_CUR_B);
    q_dir_s      = is_try_s ? req_dir_q : cur_dir_q;
    q_cand_s     = calc_cand(q_dir_s, pac_x_q, pac_y_q);
    q_tiles_s    = corner_tiles(q_dir_s, q_cand_s.nx, q_cand_s.ny, sel_b_s);
    fail_state_s = is_try_s ? ST_CUR_A : ST_DONE;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          req_dir_d = pick_dir(dir_btn, cur_dir_q);
          state_d   = (req_dir_d == cur_dir_q) ? ST_CUR_A : ST_TRY_A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRY_A, ST_TRY_B, ST_CUR_A, ST_CUR_B: begin
        // Each query state enters with wall_req low. It first issues the request,
        // then waits for the ack. An off-screen candidate skips the lookup.
        if (!wall_req_q) begin
          if (q_cand_s.oob) begin
            state_d = fail_state_s;
          end else begin
            wall_req_d = 1'b1;
            wall_tx_d  = q_tiles_s[17:9];
            wall_ty_d  = q_tiles_s[8:0];
          end
        end else if (wall_ack) begin
          wall_req_d = 1'b0;
          if (wall_hit) begin
            state_d = fail_state_s;
          end else if (state_q == ST_TRY_A) begin
            state_d = ST_TRY_B;
          end else if (state_q == ST_TRY_B) begin
            cur_dir_d = req_dir_q;
            state_d   = ST_UPDATE;
          end else if (state_q == ST_CUR_A) begin
            state_d = ST_CUR_B;
          end else begin
            state_d = ST_UPDATE;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_UPDATE: begin
        // cur_dir is already committed here, so the candidate is for cur_dir.
        pac_x_d = 12'(q_cand_s.nx);
        pac_y_d = 12'(q_cand_s.ny);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          mouth_d = ~mouth_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    move_done_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  assign wall_req    = wall_req_q;
  assign wall_tx     = wall_tx_q;
  assign wall_ty     = wall_ty_q;
  assign pac_x       = pac_x_q;
  assign pac_y       = pac_y_q;
  assign mouth_state = mouth_q;
  assign cur_dir     = cur_dir_q;
  assign busy        = busy_q;
  assign move_done   = move_done_q;

endmodule
